// File: rtl/tri_raster_sched.sv
// Triangle raster scheduler: latches one triangle, computes its clamped
// bounding box and signed area, then walks the box row-major and streams
// every covered pixel over a valid/ready handshake.
module tri_raster_sched #(
  parameter int CW       = 12,
  parameter int SCREEN_W = 320,
  parameter int SCREEN_H = 240
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 tri_valid,
  output logic                 tri_ready,
  input  logic signed [CW-1:0] tri_x0,
  input  logic signed [CW-1:0] tri_y0,
  input  logic signed [CW-1:0] tri_x1,
  input  logic signed [CW-1:0] tri_y1,
  input  logic signed [CW-1:0] tri_x2,
  input  logic signed [CW-1:0] tri_y2,
  output logic                 pix_valid,
  input  logic                 pix_ready,
  output logic [CW-1:0]        pix_x,
  output logic [CW-1:0]        pix_y,
  output logic                 done,
  output logic [31:0]          tested_cnt
);

  localparam int EW = 2*CW + 3;
  localparam logic signed [CW-1:0] X_LAST = CW'(SCREEN_W - 1);
  localparam logic signed [CW-1:0] Y_LAST = CW'(SCREEN_H - 1);

  typedef enum logic [1:0] {IDLE, SETUP, SCAN, DONE} state_t;

  state_t state, state_nx;

  logic signed [CW-1:0] x0, y0, x1, y1, x2, y2;
  logic signed [CW-1:0] xmin, xmax, ymin, ymax;
  logic signed [CW-1:0] cx, cy;

  // Sign-extend a coordinate to the exact edge-function width.
  function automatic logic signed [EW-1:0] ext(input logic signed [CW-1:0] a);
    return {{(EW-CW){a[CW-1]}}, a};
  endfunction

  function automatic logic signed [CW-1:0] min3(input logic signed [CW-1:0] a, b, c);
    logic signed [CW-1:0] m;
    m = (a < b) ? a : b;
    return (c < m) ? c : m;
  endfunction

  function automatic logic signed [CW-1:0] max3(input logic signed [CW-1:0] a, b, c);
    logic signed [CW-1:0] m;
    m = (a > b) ? a : b;
    return (c > m) ? c : m;
  endfunction

  // Which side of edge (b,c) point a lies on; zero means on the edge line.
  function automatic logic signed [EW-1:0] side(input logic signed [EW-1:0] ax, ay, bx, by, qx, qy);
    return (ax - qx) * (by - qy) - (bx - qx) * (ay - qy);
  endfunction

  // Setup terms: raw bbox, clamped bbox, twice the signed area.
  logic signed [CW-1:0] xmin_r, xmax_r, ymin_r, ymax_r;
  logic signed [CW-1:0] xmin_c, xmax_c, ymin_c, ymax_c;
  logic signed [EW-1:0] area;
  logic                 skip;

  assign xmin_r = min3(x0, x1, x2);
  assign xmax_r = max3(x0, x1, x2);
  assign ymin_r = min3(y0, y1, y2);
  assign ymax_r = max3(y0, y1, y2);
  assign xmin_c = xmin_r[CW-1] ? '0 : xmin_r;
  assign ymin_c = ymin_r[CW-1] ? '0 : ymin_r;
  assign xmax_c = (xmax_r > X_LAST) ? X_LAST : xmax_r;
  assign ymax_c = (ymax_r > Y_LAST) ? Y_LAST : ymax_r;
  assign area   = ext(x0) * (ext(y1) - ext(y2))
                + ext(x1) * (ext(y2) - ext(y0))
                + ext(x2) * (ext(y0) - ext(y1));
  assign skip   = (area == '0) || xmax_r[CW-1] || ymax_r[CW-1] ||
                  (xmin_r > X_LAST) || (ymin_r > Y_LAST);

  // Scan terms for the current pixel.
  logic signed [EW-1:0] d1, d2, d3;
  logic                 covered, stall, last_pix;

  assign d1       = side(ext(cx), ext(cy), ext(x0), ext(y0), ext(x1), ext(y1));
  assign d2       = side(ext(cx), ext(cy), ext(x1), ext(y1), ext(x2), ext(y2));
  assign d3       = side(ext(cx), ext(cy), ext(x2), ext(y2), ext(x0), ext(y0));
  assign covered  = !((d1 < 0 || d2 < 0 || d3 < 0) && (d1 > 0 || d2 > 0 || d3 > 0));
  assign stall    = pix_valid && !pix_ready;
  assign last_pix = (cx == xmax) && (cy == ymax);

  assign tri_ready = (state == IDLE);
  assign done      = (state == DONE) && !pix_valid;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // Next-state logic.
  always_comb begin
    // NOTE: assigning the default before the case keeps every path driven, so no latch is inferred.
    state_nx = state;
    unique case (state)
      IDLE:  if (tri_valid)           state_nx = SETUP;
      SETUP: state_nx = skip ? DONE : SCAN;
      SCAN:  if (!stall && last_pix)  state_nx = DONE;
      DONE:  if (!pix_valid)          state_nx = IDLE;
      default:                        state_nx = IDLE;
    endcase
  end

  // Vertex latch, bbox setup, scan walk and pixel output register.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: every register here is plain state with a defined reset value; updates use <= so all read pre-edge values.
    if (!rst_n) begin
      {x0, y0, x1, y1, x2, y2} <= '0;
      {xmin, xmax, ymin, ymax} <= '0;
      cx         <= '0;
      cy         <= '0;
      pix_valid  <= 1'b0;
      pix_x      <= '0;
      pix_y      <= '0;
      tested_cnt <= '0;
    end else begin
      if (pix_valid && pix_ready) pix_valid <= 1'b0;
      unique case (state)
        IDLE: if (tri_valid) begin
          x0 <= tri_x0; y0 <= tri_y0;
          x1 <= tri_x1; y1 <= tri_y1;
          x2 <= tri_x2; y2 <= tri_y2;
        end
        SETUP: begin
          xmin <= xmin_c; xmax <= xmax_c;
          ymin <= ymin_c; ymax <= ymax_c;
          cx   <= xmin_c; cy   <= ymin_c;
        end
        SCAN: if (!stall) begin
          tested_cnt <= tested_cnt + 32'd1;
          if (covered) begin
            pix_valid <= 1'b1;
            pix_x     <= cx;
            pix_y     <= cy;
          end
          if (cx == xmax) begin
            cx <= xmin;
            cy <= cy + CW'(1);
          end else begin
            cx <= cx + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_tri_raster_sched.sv
// Directed bench for tri_raster_sched: table of triangles with expected pixel
// sets, test counts and done timing, plus a mid-scan reset sequence.
module tb_tri_raster_sched;

  localparam int CW = 12;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic                 tri_valid = 1'b0;
  logic                 tri_ready;
  logic signed [CW-1:0] tri_x0 = '0, tri_y0 = '0, tri_x1 = '0, tri_y1 = '0, tri_x2 = '0, tri_y2 = '0;
  logic                 pix_valid;
  logic                 pix_ready = 1'b0;
  logic [CW-1:0]        pix_x, pix_y;
  logic                 done;
  logic [31:0]          tested_cnt;

  int checks = 0;
  int errors = 0;

  tri_raster_sched #(.CW(CW), .SCREEN_W(320), .SCREEN_H(240)) dut (
    .clk(clk), .rst_n(rst_n),
    .tri_valid(tri_valid), .tri_ready(tri_ready),
    .tri_x0(tri_x0), .tri_y0(tri_y0), .tri_x1(tri_x1),
    .tri_y1(tri_y1), .tri_x2(tri_x2), .tri_y2(tri_y2),
    .pix_valid(pix_valid), .pix_ready(pix_ready),
    .pix_x(pix_x), .pix_y(pix_y),
    .done(done), .tested_cnt(tested_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // diag >= 0: covered set is x,y >= 0 with x+y <= diag; diag < 0: no pixels.
  // done_cyc / first_cyc count negedges after the accept edge; -1 = not checked.
  typedef struct {
    string name;
    int    x0, y0, x1, y1, x2, y2;
    bit    toggle;
    int    diag;
    int    tested;
    int    done_cyc;
    int    first_cyc;
  } vec_t;

  task automatic run_tri(input vec_t v);
    int       exp_x[$], exp_y[$], got_x[$], got_y[$];
    int       done_cnt, done_cyc, first_valid, cyc, k, n;
    logic [31:0]   t0;
    bit            prev_stall, fin, rdy;
    logic [CW-1:0] px_prev, py_prev;
    done_cnt = 0; done_cyc = -1; first_valid = -1; k = 0;
    prev_stall = 0; fin = 0; px_prev = '0; py_prev = '0;
    if (v.diag >= 0)
      for (int y = 0; y <= v.diag; y++)
        for (int x = 0; x <= v.diag - y; x++) begin
          exp_x.push_back(x);
          exp_y.push_back(y);
        end
    @(negedge clk);
    check({v.name, " tri_ready idle"}, 32'(tri_ready), 32'd1);
    t0 = tested_cnt;
    tri_x0 = CW'(v.x0); tri_y0 = CW'(v.y0);
    tri_x1 = CW'(v.x1); tri_y1 = CW'(v.y1);
    tri_x2 = CW'(v.x2); tri_y2 = CW'(v.y2);
    tri_valid = 1'b1;
    pix_ready = 1'b1;
    @(negedge clk);
    tri_valid = 1'b0;
    tri_x0 = 12'sd99; tri_y0 = 12'sd99;
    cyc = 1;
    while (!fin && cyc < 400) begin
      if (pix_valid && first_valid < 0) first_valid = cyc;
      if (prev_stall) begin
        check({v.name, " stall valid"}, 32'(pix_valid), 32'd1);
        check({v.name, " stall x"}, 32'(pix_x), 32'(px_prev));
        check({v.name, " stall y"}, 32'(pix_y), 32'(py_prev));
      end
      if (done_cyc >= 0) begin
        check({v.name, " ready after done"}, 32'(tri_ready), 32'd1);
        check({v.name, " done one cycle"}, 32'(done), 32'd0);
        fin = 1;
      end else if (done) begin
        done_cnt++;
        done_cyc = cyc;
        check({v.name, " no pending at done"}, 32'(pix_valid), 32'd0);
      end
      rdy = v.toggle ? !((k % 4 == 1) || (k % 4 == 2)) : 1'b1;
      k++;
      pix_ready = rdy;
      if (pix_valid && rdy) begin
        got_x.push_back(int'(pix_x));
        got_y.push_back(int'(pix_y));
      end
      prev_stall = pix_valid && !rdy;
      px_prev = pix_x;
      py_prev = pix_y;
      if (!fin) begin
        @(negedge clk);
        cyc++;
      end
    end
    check({v.name, " finished in budget"}, 32'(fin), 32'd1);
    check({v.name, " pixel count"}, 32'(got_x.size()), 32'(exp_x.size()));
    n = (got_x.size() < exp_x.size()) ? got_x.size() : exp_x.size();
    for (int i = 0; i < n; i++) begin
      check($sformatf("%s pix %0d x", v.name, i), 32'(got_x[i]), 32'(exp_x[i]));
      check($sformatf("%s pix %0d y", v.name, i), 32'(got_y[i]), 32'(exp_y[i]));
    end
    check({v.name, " tested delta"}, tested_cnt - t0, 32'(v.tested));
    check({v.name, " done pulses"}, 32'(done_cnt), 32'd1);
    if (v.done_cyc >= 0)  check({v.name, " done cycle"}, 32'(done_cyc), 32'(v.done_cyc));
    if (v.first_cyc >= 0) check({v.name, " first pix cycle"}, 32'(first_valid), 32'(v.first_cyc));
    pix_ready = 1'b1;
  endtask

  vec_t vecs[5];

  initial begin
    int n;
    vecs[0] = '{"tri1",     0,   0,  4,   0,   0,  4, 1'b0,  4, 25, 27,  3};
    vecs[1] = '{"tri1_rev", 0,   0,  0,   4,   4,  0, 1'b0,  4, 25, 27,  3};
    vecs[2] = '{"degen",    0,   0,  2,   2,   4,  4, 1'b0, -1,  0,  2, -1};
    vecs[3] = '{"clamped", -10, -10, 5, -10, -10,  5, 1'b0, -1, 36, 38, -1};
    vecs[4] = '{"toggle",   0,   0,  4,   0,   0,  4, 1'b1,  4, 25, -1,  3};

    // Reset values while rst_n is held low.
    #2;
    check("reset tri_ready", 32'(tri_ready), 32'd1);
    check("reset pix_valid", 32'(pix_valid), 32'd0);
    check("reset done", 32'(done), 32'd0);
    check("reset tested_cnt", tested_cnt, 32'd0);
    check("reset pix_x", 32'(pix_x), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 5; i++) run_tri(vecs[i]);

    // Reset after three pixels have been presented mid-scan.
    @(negedge clk);
    tri_x0 = 12'sd0; tri_y0 = 12'sd0;
    tri_x1 = 12'sd4; tri_y1 = 12'sd0;
    tri_x2 = 12'sd0; tri_y2 = 12'sd4;
    tri_valid = 1'b1;
    pix_ready = 1'b1;
    @(negedge clk);
    tri_valid = 1'b0;
    n = 0;
    for (int c = 0; c < 100 && n < 3; c++) begin
      @(negedge clk);
      if (pix_valid) n++;
    end
    check("mid reset pixels seen", 32'(n), 32'd3);
    rst_n = 1'b0;
    #1;
    check("mid reset pix_valid", 32'(pix_valid), 32'd0);
    check("mid reset tri_ready", 32'(tri_ready), 32'd1);
    check("mid reset tested_cnt", tested_cnt, 32'd0);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("held reset done", 32'(done), 32'd0);
      check("held reset pix_valid", 32'(pix_valid), 32'd0);
    end
    rst_n = 1'b1;
    run_tri(vecs[0]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
